// File: rtl/cd_pkg.sv
// Shared constants and types for the CDBUS frame reader.
//   CD_HDR_LEN     header bytes before the payload (src, dst, len)
//   CD_MAX_DATA    largest payload length honoured; longer len fields are clamped
//   CD_FIFO_DEPTH  entries in the tagged return FIFO
//   cd_rd_state_t  reader FSM state
//   cd_tag_entry_t one FIFO entry: frame byte plus its index within the frame
package cd_pkg;

  localparam int unsigned CD_HDR_LEN    = 3;
  localparam int unsigned CD_MAX_DATA   = 253;
  localparam int unsigned CD_FIFO_DEPTH = 4;
  localparam int unsigned CD_CNT_W      = $clog2(CD_FIFO_DEPTH + 1);

  typedef enum logic [0:0] {IDLE, RUN} cd_rd_state_t;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] data;
  } cd_tag_entry_t;

  // Index of the final frame byte for a given len field; clamping keeps it within 8 bits.
  function automatic logic [7:0] cd_last_idx(input logic [7:0] len);
    if (len > 8'(CD_MAX_DATA)) begin
      return 8'(CD_MAX_DATA + CD_HDR_LEN - 1);
    end
    return len + 8'(CD_HDR_LEN - 1);
  endfunction

endpackage

// File: rtl/cd_tag_fifo.sv
// Small shift-register FIFO of (byte, index) pairs. Entry 0 is always the head.
//   clk, reset_n          clock, synchronous active-low reset
//   flush                 drop every entry (dominates all other requests)
//   pop                   remove the head
//   purge, purge_idx      drop every entry whose index exceeds purge_idx
//   push, push_data/idx   append an entry (applied after pop and purge)
//   count                 current occupancy
//   head_data, head_idx   head entry contents
module cd_tag_fifo
  import cd_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                pop,
  input  logic                purge,
  input  logic [7:0]          purge_idx,
  input  logic                push,
  input  logic [7:0]          push_data,
  input  logic [7:0]          push_idx,
  output logic [CD_CNT_W-1:0] count,
  output logic [7:0]          head_data,
  output logic [7:0]          head_idx
);

  localparam int unsigned PtrW = $clog2(CD_FIFO_DEPTH);

  cd_tag_entry_t       mem_q [CD_FIFO_DEPTH];
  cd_tag_entry_t       mem_d [CD_FIFO_DEPTH];
  logic [CD_CNT_W-1:0] cnt_q, cnt_d;
  logic [CD_CNT_W-1:0] keep;
  logic                stop;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    keep  = '0;
    stop  = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (pop && cnt_q != '0) begin
        for (int i = 0; i < int'(CD_FIFO_DEPTH) - 1; i++) begin
          mem_d[i] = mem_q[i + 1];
        end
        cnt_d = cnt_q - 1'b1;
      end
      // Indices are stored in ascending order, so keep the leading run that fits.
      if (purge) begin
        for (int i = 0; i < int'(CD_FIFO_DEPTH); i++) begin
          if (!stop && CD_CNT_W'(i) < cnt_d && mem_d[i].idx <= purge_idx) begin
            keep = CD_CNT_W'(i + 1);
          end else begin
            stop = 1'b1;
          end
        end
        cnt_d = keep;
      end
      if (push && cnt_d < CD_CNT_W'(CD_FIFO_DEPTH)) begin
        mem_d[cnt_d[PtrW-1:0]] = '{idx: push_idx, data: push_data};
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign count     = cnt_q;
  assign head_data = mem_q[0].data;
  assign head_idx  = mem_q[0].idx;

endmodule

// File: rtl/cd_frame_reader.sv
// Streams one CDBUS frame (src, dst, len, len data bytes) from SRAM address 0 onto a
// valid/ready byte stream, marking the final byte with out_last.
//   clk, reset_n        clock, synchronous active-low reset
//   start, abort        begin a frame (ignored while busy) / cancel it (highest priority)
//   busy, done          frame in progress / pulse on the final byte's handshake
//   ra, re, rd          SRAM read port; rd is valid the cycle after re
//   out_data/valid/ready/last  byte stream
// Reads are issued ahead of the stream while FIFO occupancy plus reads in flight stays
// below the FIFO depth, so a stalled sink can never overflow the FIFO. Reads issued before
// the len byte returns are speculative; returns beyond the final index are dropped.
module cd_frame_reader
  import cd_pkg::*;
#(
  parameter int unsigned A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] ra,
  output logic               re,
  input  logic [7:0]         rd,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  cd_rd_state_t        state_q, state_d;

  logic                re_q, rvalid_q;
  logic [A_WIDTH-1:0]  ra_q;
  logic [7:0]          tag_q;       // index of the read now at the SRAM
  logic [7:0]          rtag_q;      // index of the byte now on rd
  logic [8:0]          rd_idx_q, rd_idx_d;
  logic                len_known_q, len_known_d;
  logic [7:0]          last_idx_q, last_idx_d;

  logic [CD_CNT_W-1:0] fifo_cnt, pending;
  logic [7:0]          head_data, head_idx, new_last, issue_tag;
  logic                start_ok, hs, fin, len_hit, keep_rtn, push, can_more;
  logic                issue_run, issue;

  assign start_ok  = (state_q == IDLE) && start && !abort;
  assign hs        = out_valid && out_ready;
  assign fin       = hs && out_last && !abort;

  assign len_hit   = (state_q == RUN) && rvalid_q && !len_known_q &&
                     (rtag_q == 8'(CD_HDR_LEN - 1));
  assign new_last  = cd_last_idx(rd);
  assign keep_rtn  = !len_known_q || (rtag_q <= last_idx_q);
  assign push      = (state_q == RUN) && rvalid_q && keep_rtn && !abort;

  assign pending   = fifo_cnt + CD_CNT_W'(re_q) + CD_CNT_W'(rvalid_q);
  assign can_more  = !len_known_q || (rd_idx_q <= {1'b0, last_idx_q});
  assign issue_run = (state_q == RUN) && !abort && !fin && can_more &&
                     (pending < CD_CNT_W'(CD_FIFO_DEPTH));
  // The start cycle issues index 0 directly so the first read leaves one cycle later.
  assign issue     = start_ok || issue_run;
  assign issue_tag = start_ok ? 8'd0 : rd_idx_q[7:0];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN:  if (abort || fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == RUN);
  end

  always_comb begin
    rd_idx_d    = rd_idx_q;
    len_known_d = len_known_q;
    last_idx_d  = last_idx_q;
    if (start_ok) begin
      rd_idx_d    = 9'd1;
      len_known_d = 1'b0;
      last_idx_d  = '0;
    end else begin
      if (issue_run) rd_idx_d = rd_idx_q + 9'd1;
      if (len_hit) begin
        len_known_d = 1'b1;
        last_idx_d  = new_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      re_q        <= 1'b0;
      ra_q        <= '0;
      tag_q       <= '0;
      rvalid_q    <= 1'b0;
      rtag_q      <= '0;
      rd_idx_q    <= '0;
      len_known_q <= 1'b0;
      last_idx_q  <= '0;
    end else begin
      re_q        <= issue;
      if (issue) begin
        ra_q  <= A_WIDTH'(issue_tag);
        tag_q <= issue_tag;
      end
      // Abort or frame end drops the read still in flight.
      rvalid_q    <= re_q && (state_q == RUN) && !abort && !fin;
      rtag_q      <= tag_q;
      rd_idx_q    <= rd_idx_d;
      len_known_q <= len_known_d;
      last_idx_q  <= last_idx_d;
    end
  end

  cd_tag_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .pop       (hs),
    .purge     (len_hit),
    .purge_idx (new_last),
    .push      (push),
    .push_data (rd),
    .push_idx  (rtag_q),
    .count     (fifo_cnt),
    .head_data (head_data),
    .head_idx  (head_idx)
  );

  assign re        = re_q;
  assign ra        = ra_q;
  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? head_data : 8'd0;
  assign out_last  = out_valid && len_known_q && (head_idx == last_idx_q);
  assign done      = fin;

endmodule

// File: tb/tb_cd_frame_reader.sv
module tb_cd_frame_reader;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, out_ready;
  logic          busy, done, re, out_valid, out_last;
  logic [AW-1:0] ra;
  logic [7:0]    rd, out_data;

  logic [7:0] mem [256];
  logic [7:0] t1_bytes [6] = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Frame model: the expected stream is mem[0 .. min(mem[2],253)+2].
  bit         active = 0, busy_m = 0, prev_hold = 0, busy_now;
  int         ptr, exp_last, next_ra, issued, hs_cnt, max_ra;
  int         frames_done = 0, last_frame_bytes = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  cd_frame_reader #(.A_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .ra        (ra),
    .re        (re),
    .rd        (rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (re) rd <= mem[ra];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the frame model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        active = 0; busy_m = 0; prev_hold = 0;
      end else begin
        busy_now = busy_m;
        chk("busy", int'(busy), int'(busy_m));
        if (re) begin
          if (active) begin
            chk("ra_seq", int'(ra), next_ra);
            if (next_ra <= exp_last) issued++;
            max_ra = int'(ra);
            next_ra++;
          end else begin
            chk("re_idle", int'(re), 0);
          end
        end
        if (abort) begin
          chk("done_abort", int'(done), 0);
          active = 0; busy_m = 0; prev_hold = 0;
        end else if (active) begin
          if (prev_hold) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'(prev_data));
            chk("hold_last", int'(out_last), int'(prev_last));
          end
          chk("outstanding_le4", int'((issued - hs_cnt) <= 4), 1);
          if (out_valid) begin
            chk("data", int'(out_data), int'(mem[ptr]));
            chk("last", int'(out_last), int'(ptr == exp_last));
            if (out_ready) begin
              chk("done", int'(done), int'(ptr == exp_last));
              hs_cnt++;
              ptr++;
              if (ptr > exp_last) begin
                active = 0; busy_m = 0;
                frames_done++;
                last_frame_bytes = hs_cnt;
              end
            end else begin
              chk("done_stall", int'(done), 0);
            end
          end else begin
            chk("done_novalid", int'(done), 0);
          end
          prev_hold = out_valid && !out_ready;
          prev_data = out_data;
          prev_last = out_last;
        end else begin
          chk("valid_idle", int'(out_valid), 0);
          chk("done_idle", int'(done), 0);
          prev_hold = 0;
        end
        if (start && !busy_now && !abort) begin
          active = 1; busy_m = 1; prev_hold = 0;
          ptr = 0; next_ra = 0; issued = 0; hs_cnt = 0; max_ra = -1;
          exp_last = (mem[2] > 8'd253) ? 255 : int'(mem[2]) + 2;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a posedge; returns #1 after the next posedge (cycle 1 of the frame).
  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_frame(input int target, input int bound);
    int k = 0;
    while (frames_done < target && k < bound) begin
      step(1);
      k++;
    end
    chk("frame_complete", frames_done, target);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_re", int'(re), 0);
    chk("rst_ra", int'(ra), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_data", int'(out_data), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(2);

    // Basic frame, exact cycle timing.
    for (int i = 0; i < 6; i++) mem[i] = t1_bytes[i];
    do_start();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("t1_busy", int'(busy), int'(c <= 8));
      chk("t1_valid", int'(out_valid), int'(c >= 3 && c <= 8));
      chk("t1_done", int'(done), int'(c == 8));
      if (c >= 3 && c <= 8) begin
        chk("t1_data", int'(out_data), int'(t1_bytes[c-3]));
        chk("t1_last", int'(out_last), int'(c == 8));
      end
      if (c <= 2) begin
        chk("t1_re", int'(re), 1);
        chk("t1_ra", int'(ra), c - 1);
      end
      step(1);
    end
    chk("t1_frames", frames_done, 1);

    // len = 0: three bytes, over-read never streamed.
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h06; mem[2] = 8'h00; mem[3] = 8'h77; mem[4] = 8'h88;
    step(1);
    do_start();
    wait_frame(2, 50);
    chk("t2_bytes", last_frame_bytes, 3);

    // len = 0xFF: clamped to 253, 256 bytes, final address 255.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[2] = 8'hFF;
    step(1);
    do_start();
    wait_frame(3, 400);
    chk("t3_bytes", last_frame_bytes, 256);
    chk("t3_max_ra", max_ra, 255);

    // len = 20 with random backpressure and a start while busy.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[2] = 8'd20;
    step(1);
    do_start();
    for (int k = 0; k < 600 && frames_done < 4; k++) begin
      out_ready = 1'($urandom_range(1));
      start = (k == 10);
      step(1);
    end
    out_ready = 1'b1; start = 1'b0;
    chk("t4_frames", frames_done, 4);
    chk("t4_bytes", last_frame_bytes, 23);

    // Abort on byte 5 of a len = 10 frame, then restart.
    mem[2] = 8'd10;
    step(2);
    do_start();
    step(7);
    abort = 1'b1;
    @(negedge clk);
    chk("t5_byte5", int'(out_data), int'(mem[5]));
    step(1);
    abort = 1'b0;
    @(negedge clk);
    chk("t5_valid_after", int'(out_valid), 0);
    chk("t5_busy_after", int'(busy), 0);
    step(5);
    chk("t5_no_done", frames_done, 4);
    do_start();
    wait_frame(5, 100);
    chk("t5_bytes", last_frame_bytes, 13);

    // One-cycle reset mid-frame, then a normal frame.
    step(2);
    do_start();
    step(5);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    step(1);
    do_start();
    wait_frame(6, 100);
    chk("t6_bytes", last_frame_bytes, 13);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cd_frame_reader.md
# cd_frame_reader

Streams one CDBUS frame out of a `cd_sram` buffer page. It drives the SRAM read port (`ra`/`re`, one-cycle read latency on `rd`) and emits bytes on a valid/ready byte stream with `out_last` on the final byte. It sits between a TX frame buffer and the serializer, as the read-side counterpart of the frame writer that fills the SRAM. Frame layout: byte 0 src, byte 1 dst, byte 2 len, then len data bytes.

## Interface
- `A_WIDTH`, 8, SRAM address width; must be ≥ 8.
- `clk`  in  1  clock; single clock domain.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to stream the frame at address 0; ignored while `busy`.
- `abort`  in  1  cancel the current frame; has priority over all other events.
- `busy`  out  1  high from the cycle after `start` until the cycle after the `done` or `abort` cycle.
- `done`  out  1  one-cycle pulse on the cycle the last byte handshakes.
- `ra`  out  A_WIDTH  SRAM read address, registered.
- `re`  out  1  SRAM read enable, registered.
- `rd`  in  8  SRAM read data, valid the cycle after `re`.
- `out_data`  out  8  stream byte.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  marks the final frame byte; qualified by `out_valid`.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: issue reads and stream bytes.
  - IDLE again after the last byte handshakes.
- `start` in IDLE sets rd_idx=0, wr_idx=0, len_known=0, and moves to RUN.
- Read issue in RUN: a read issues when `occupancy + inflight < 4` and `rd_idx ≤ last_idx` (or `!len_known`).
  - A read sets `re=1`, `ra=rd_idx`, then increments rd_idx.
  - `inflight` counts issued reads whose data has not yet returned; range 0..2.
- Return path: each returned `rd` byte is tagged with its index.
  - Index ≤ last_idx, or `!len_known`: push into the 4-entry FIFO.
  - Otherwise discard (speculative over-read; no other effect).
- Length: when the index-2 byte returns, latch `len_c = min(len, 253)` and set `last_idx = len_c + 2` (9-bit arithmetic, max 255).
  - Any already-pushed entries with index > last_idx are purged from the FIFO.
- `out_last = (head index == last_idx) && len_known`.
- Handshake: `out_valid && out_ready` pops the FIFO. If that byte is last, `done` pulses and the state returns to IDLE.
- `abort`: next cycle the state is IDLE, the FIFO is flushed, `inflight` is cleared, and late returns are ignored. `done` does not pulse.
- Reset values: `busy=0`, `done=0`, `re=0`, `ra=0`, `out_valid=0`, `out_last=0`, `out_data=0`. The state is IDLE.
- Reset mid-frame behaves as `abort`, plus all registers go to their reset values.

## Timing
- `start` high in cycle 0:
  - `re=1`, `ra=0` in cycle 1.
  - `rd` valid in cycle 2.
  - `out_valid=1`, `out_data` = byte 0 in cycle 3.
- With `out_ready` held high, throughput is 1 byte per clock.
  - A frame of len L completes with `done` in cycle L+5.
- `out_valid` low→high only at a FIFO push. Once high, `out_data`, `out_valid` and `out_last` hold stable until the handshake.
- Dropping `out_ready` stops read issue within 1 cycle. No byte is lost: FIFO depth 4 ≥ occupancy + 2 in flight.
- `start` and `abort` in the same cycle: `abort` wins and the state stays IDLE.
- `start` while `busy`: ignored.

## Structure
- Package `cd_pkg`:
  - Constants `CD_HDR_LEN=3`, `CD_MAX_DATA=253`, `CD_FIFO_DEPTH=4`.
  - State enum `cd_rd_state_t` {IDLE, RUN}.
- Sub-module `cd_tag_fifo`: 4×(8-bit data + 8-bit index), with push, pop, flush, and purge-above-index.

## Test plan
- Frame {0x01, 0x02, 0x03, AA, BB, CC}, `out_ready=1`, `start` at cycle 0:
  - bytes 01 02 03 AA BB CC appear in cycles 3–8.
  - `out_last` and `done` occur in cycle 8.
  - `busy` falls in cycle 9.
- len=0 frame {05, 06, 00}:
  - exactly 3 bytes are output, `out_last` on 00.
  - the index-3 over-read never appears on the stream.
- len=0xFF:
  - clamped to 253; 256 bytes are streamed with `ra` 0..255.
  - `out_last` is on index 255 and no address wraps.
- Random `out_ready` (50 %) over a len=20 frame:
  - byte sequence is identical to memory.
  - `out_data` is stable while `out_valid && !out_ready`.
  - `inflight + occupancy ≤ 4` at all times.
- `abort` at byte 5 of a len=10 frame:
  - `out_valid=0` and `busy=0` the next cycle; no `done`.
  - a following `start` streams the full frame correctly.
- `reset_n=0` for 1 cycle mid-frame: all outputs read their reset values in the next cycle, and `start` is then accepted normally.
